// File: rtl/cycle_phase_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : cycle_phase_tracker
//  Purpose  : Receive side of the bus-cycle strobe set (cycsel/mhz4/addrsel/
//             latch). Recovers the 8-clk bus-cycle phase, declares lock after
//             a run of clean frames and counts frames that break the pattern.
//  Revision : 1.0 - initial release
// ============================================================================
module cycle_phase_tracker #(
  parameter int unsigned LOCK_FRAMES   = 4,
  parameter int unsigned UNLOCK_FRAMES = 2,
  parameter logic [7:0]  CYC_PATTERN   = 8'b00001111,
  parameter logic [7:0]  M4_PATTERN    = 8'b00110011,
  parameter logic [7:0]  AS_PATTERN    = 8'b00011110,
  parameter bit          CHECK_AS      = 1'b1
) (
  input  logic       clk,
  input  logic       res,
  input  logic       cycsel_in,
  input  logic       mhz4_in,
  input  logic       addrsel_in,
  input  logic       latch_in,
  output logic [2:0] phase,
  output logic       frame_start,
  output logic       locked,
  output logic       lost,
  output logic       latch_q,
  output logic [7:0] err_count
);

  localparam logic [3:0] C_LOCK_FRAMES   = 4'(LOCK_FRAMES);
  localparam logic [3:0] C_UNLOCK_FRAMES = 4'(UNLOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Input sample stage
  logic s_cyc_q, s_m4_q, s_as_q, s_lat_q, s_cyc_prev_q;

  // Tracker state
  state_t     state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic       frame_start_q, frame_start_d;
  logic       locked_q, locked_d;
  logic       lost_q, lost_d;
  logic       lat_out_q;
  logic [7:0] err_q, err_d;
  logic [3:0] good_q, good_d;
  logic [3:0] bad_run_q, bad_run_d;
  logic       frame_bad_q, frame_bad_d;

  // Combinational helpers
  logic [2:0] w_phase_nxt;
  logic [2:0] w_phase_sel;
  logic       w_mismatch;
  logic       w_frame_bad_now;
  logic [7:0] w_err_inc;

  // Capture the strobes once; keep the previous cycsel for edge detection
  always_ff @(posedge clk) begin
    if (res) begin
      s_cyc_q      <= 1'b0;
      s_m4_q       <= 1'b0;
      s_as_q       <= 1'b0;
      s_lat_q      <= 1'b0;
      s_cyc_prev_q <= 1'b0;
    end else begin
      s_cyc_q      <= cycsel_in;
      s_m4_q       <= mhz4_in;
      s_as_q       <= addrsel_in;
      s_lat_q      <= latch_in;
      s_cyc_prev_q <= s_cyc_q;
    end
  end

  // Phase being processed at this edge and its pattern comparison
  always_comb begin
    w_phase_nxt     = phase_q + 3'd1;
    w_phase_sel     = (state_q == ST_HUNT) ? 3'd0 : w_phase_nxt;
    w_mismatch      = (s_cyc_q != CYC_PATTERN[w_phase_sel])
                    | (s_m4_q  != M4_PATTERN[w_phase_sel])
                    | (CHECK_AS & (s_as_q != AS_PATTERN[w_phase_sel]));
    w_frame_bad_now = frame_bad_q | w_mismatch;
    w_err_inc       = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  end

  // Next-state logic: edge search, phase tracking and frame accounting
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    frame_start_d = 1'b0;
    locked_d      = locked_q;
    lost_d        = 1'b0;
    err_d         = err_q;
    good_d        = good_q;
    bad_run_d     = bad_run_q;
    frame_bad_d   = frame_bad_q;

    case (state_q)
      ST_HUNT: begin
        phase_d     = 3'd0;
        locked_d    = 1'b0;
        frame_bad_d = 1'b0;
        if (s_cyc_q && !s_cyc_prev_q) begin
          // This sample is phase 0 and is matched right away
          frame_start_d = 1'b1;
          state_d       = ST_CHECK;
          good_d        = 4'd0;
          bad_run_d     = 4'd0;
          frame_bad_d   = w_mismatch;
        end
      end

      ST_CHECK, ST_LOCKED: begin
        phase_d       = w_phase_nxt;
        frame_start_d = (w_phase_nxt == 3'd0);
        frame_bad_d   = w_frame_bad_now;
        if (w_phase_nxt == 3'd7) begin
          frame_bad_d = 1'b0;
          if (w_frame_bad_now) begin
            err_d = w_err_inc;
          end
          if (state_q == ST_CHECK) begin
            if (w_frame_bad_now) begin
              state_d = ST_HUNT;
              good_d  = 4'd0;
            end else if ((good_q + 4'd1) == C_LOCK_FRAMES) begin
              state_d   = ST_LOCKED;
              locked_d  = 1'b1;
              good_d    = 4'd0;
              bad_run_d = 4'd0;
            end else begin
              good_d = good_q + 4'd1;
            end
          end else begin
            if (!w_frame_bad_now) begin
              bad_run_d = 4'd0;
            end else if ((bad_run_q + 4'd1) == C_UNLOCK_FRAMES) begin
              state_d   = ST_HUNT;
              locked_d  = 1'b0;
              lost_d    = 1'b1;
              bad_run_d = 4'd0;
            end else begin
              bad_run_d = bad_run_q + 4'd1;
            end
          end
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  // Tracker state and registered outputs
  always_ff @(posedge clk) begin
    if (res) begin
      state_q       <= ST_HUNT;
      phase_q       <= 3'd0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      lost_q        <= 1'b0;
      lat_out_q     <= 1'b0;
      err_q         <= 8'd0;
      good_q        <= 4'd0;
      bad_run_q     <= 4'd0;
      frame_bad_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      lost_q        <= lost_d;
      lat_out_q     <= s_lat_q;
      err_q         <= err_d;
      good_q        <= good_d;
      bad_run_q     <= bad_run_d;
      frame_bad_q   <= frame_bad_d;
    end
  end

  assign phase       = phase_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign lost        = lost_q;
  assign latch_q     = lat_out_q;
  assign err_count   = err_q;

endmodule
`default_nettype wire

// File: doc/cycle_phase_tracker.md
Name: cycle_phase_tracker

Overview:
- Receive side of the bus-cycle timing strobe set (cycsel, mhz4, addrsel, latch) produced by the MCU clock generator.
- Samples the strobes on the master clock and recovers the 8-clk bus-cycle phase index. Declares lock after repeated clean frames and counts frames that break the pattern.
- Used by peripheral models and the testbench to align to bus slots without access to the generator's internal counters.

Parameters:
- LOCK_FRAMES, 4: consecutive clean frames in CHECK required to enter LOCKED (1..15).
- UNLOCK_FRAMES, 2: consecutive bad frames in LOCKED that force HUNT (1..15).
- CYC_PATTERN, 8'b00001111: bit i = expected sampled cycsel at phase i.
- M4_PATTERN, 8'b00110011: bit i = expected sampled mhz4 at phase i.
- AS_PATTERN, 8'b00011110: bit i = expected sampled addrsel at phase i.
- CHECK_AS, 1: 1 = addrsel takes part in the match; 0 = ignored.

Ports:
- clk  in  1  master clock; all logic on rising edge.
- res  in  1  synchronous active-high reset.
- cycsel_in  in  1  cycle-select strobe from the generator.
- mhz4_in  in  1  4 MHz phase strobe.
- addrsel_in  in  1  address-select strobe.
- latch_in  in  1  latch strobe; sampled and passed through only.
- phase  out  3  recovered phase of the sample currently being checked.
- frame_start  out  1  1-clk pulse when phase==0 while tracking.
- locked  out  1  high in LOCKED.
- lost  out  1  1-clk pulse on the LOCKED->HUNT transition.
- latch_q  out  1  sampled latch_in, aligned with phase.
- err_count  out  8  bad-frame count, saturating.

Behaviour:
- Reset (res high at the edge; res has priority over all events):
  - State = HUNT.
  - phase=0, frame_start=0, locked=0, lost=0, latch_q=0, err_count=0.
  - Input sample registers and all frame counters cleared.
- Input stage: one register stage s_cyc/s_m4/s_as/s_lat, plus s_cyc_d (previous s_cyc). All outputs are registered, so total latency from input to outputs is 2 clk.
- HUNT:
  - phase=0, frame_start=0.
  - When s_cyc=1 and s_cyc_d=0 at an edge: that sample is phase 0; set phase<=0 and frame_start<=1; go to CHECK with good=0 and frame_bad=0.
  - Matching of the phase-0 sample starts at that edge.
- Tracking (CHECK and LOCKED):
  - phase free-runs: +1 mod 8 each clk. No resync on cycsel edges.
  - frame_start <= (next phase==0).
  - Per edge: mismatch = (s_cyc != CYC_PATTERN[phase]) | (s_m4 != M4_PATTERN[phase]) | (CHECK_AS & s_as != AS_PATTERN[phase]).
  - A mismatch sets frame_bad, which is sticky until the end of the frame.
- End of frame (edge that processes phase 7; include that sample's mismatch):
  - Bad frame: err_count += 1, saturating at 255.
  - CHECK, clean frame: good += 1. When good reaches LOCK_FRAMES, set locked<=1 at this same edge.
  - CHECK, bad frame: go to HUNT; good cleared; no lost pulse.
  - LOCKED, clean frame: bad_run cleared.
  - LOCKED, bad frame: bad_run += 1. When bad_run reaches UNLOCK_FRAMES: go to HUNT, locked<=0, lost<=1 for one clk.
  - frame_bad is cleared for the next frame.
- A HUNT transition at the phase-7 edge does not also detect an edge in that same cycle; edge search starts on the following edge.
- err_count is cleared only by reset and never wraps.
- latch_q = s_lat delayed one clk, so it is aligned with phase in every state.

Test Plan:
- Reset, then an ideal period-8 stimulus matching all patterns; cycsel_in rises before edge k -> frame_start and phase=0 after edge k+1; locked=1 after edge k+32 (phase=7 of frame 4); err_count=0.
- Locked, then mhz4_in inverted for one clk in one frame -> err_count=1, locked stays 1, lost=0. Next frame clean -> no change.
- Locked, then cycsel_in held low for two whole frames -> err_count=2; lost pulses exactly 1 clk at phase 7 of the 2nd bad frame; locked=0. Ideal stimulus resumed -> relock after 4 clean frames.
- Stimulus with period 9 (extra clk each frame) -> never locked; err_count increments each attempt and saturates at 255 after 255 bad frames.
- res asserted for 1 clk while locked with err_count=3 -> all outputs 0 at the next edge; relock timing is identical to test 1.
- CHECK_AS=0 with addrsel_in stuck high -> locks normally; CHECK_AS=1 with the same stimulus -> never locks.
